// File: rtl/mem_pipe.sv
// MEM stage: drives data memory, stalls upstream while an access is outstanding, resolves branches to IF.
// Latency: MEM/WB registers update one edge after completion; zero-wait accesses add no stall.
// Backpressure: stall is high while the request waits for ack; an access is abandoned after TIMEOUT cycles in WAIT.
module mem_pipe #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_to_reg_xm,
    input  logic        reg_write_xm,
    input  logic        mem_read_xm,
    input  logic        mem_write_xm,
    input  logic        branch_xm,
    input  logic        fp_operation_xm,
    input  logic [31:0] alu_out_xm,
    input  logic [31:0] alu_out_fp_xm,
    input  logic [4:0]  rd_addr_xm,
    input  logic [31:0] mem_data_xm,
    input  logic [31:0] mem_data_fp_xm,
    input  logic [31:0] branch_addr_xm,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        mem_to_reg_mw,
    output logic        reg_write_mw,
    output logic        fp_operation_mw,
    output logic [31:0] alu_out_mw,
    output logic [31:0] alu_out_fp_mw,
    output logic [31:0] mem_rdata_mw,
    output logic [4:0]  rd_addr_mw,
    output logic        mem_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          mem_op;
    logic          misaligned;
    logic          abort;

    always_comb begin
        mem_op        = mem_read_xm | mem_write_xm;
        dmem_addr     = fp_operation_xm ? alu_out_fp_xm : alu_out_xm;
        dmem_wdata    = fp_operation_xm ? mem_data_fp_xm : mem_data_xm;
        dmem_we       = mem_write_xm;
        // Only judged in IDLE; an access already in WAIT passed this check when it was issued.
        misaligned    = ~rst & (state == IDLE) & mem_op & (dmem_addr[1:0] != 2'b00);
        dmem_req      = ~rst & ((state == WAIT) | (mem_op & (dmem_addr[1:0] == 2'b00)));
        abort         = ~rst & (state == WAIT) & ~dmem_ack & (cnt == CNT_LAST);
        stall         = dmem_req & ~dmem_ack & ~abort;
        pc_src        = ~rst & branch_xm & ~stall;
        branch_target = branch_addr_xm;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            mem_err         <= 1'b0;
            mem_to_reg_mw   <= 1'b0;
            reg_write_mw    <= 1'b0;
            fp_operation_mw <= 1'b0;
            alu_out_mw      <= '0;
            alu_out_fp_mw   <= '0;
            mem_rdata_mw    <= '0;
            rd_addr_mw      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dmem_req && !dmem_ack) begin
                        state <= WAIT;
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (dmem_ack || abort) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase

            mem_err <= mem_err | misaligned | abort;

            if (stall) begin
                // Bubble into WB; data fields keep their last values.
                mem_to_reg_mw   <= 1'b0;
                reg_write_mw    <= 1'b0;
                fp_operation_mw <= 1'b0;
            end else begin
                mem_to_reg_mw   <= mem_to_reg_xm & ~(misaligned | abort);
                reg_write_mw    <= reg_write_xm & ~(misaligned | abort);
                fp_operation_mw <= fp_operation_xm;
                alu_out_mw      <= alu_out_xm;
                alu_out_fp_mw   <= alu_out_fp_xm;
                rd_addr_mw      <= rd_addr_xm;
                mem_rdata_mw    <= (mem_read_xm && dmem_req && dmem_ack) ? dmem_rdata : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_mem_pipe.sv
// Self-checking bench for mem_pipe: combinational outputs checked each cycle, MEM/WB results via an expectation queue.
module tb_mem_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_to_reg_xm, reg_write_xm, mem_read_xm, mem_write_xm, branch_xm, fp_operation_xm;
    logic [31:0] alu_out_xm, alu_out_fp_xm, mem_data_xm, mem_data_fp_xm, branch_addr_xm;
    logic [4:0]  rd_addr_xm;
    logic        dmem_req, dmem_we, dmem_ack, stall, pc_src;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, branch_target;
    logic        mem_to_reg_mw, reg_write_mw, fp_operation_mw, mem_err;
    logic [31:0] alu_out_mw, alu_out_fp_mw, mem_rdata_mw;
    logic [4:0]  rd_addr_mw;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        mtr;
        logic        rw;
        logic        fp;
        logic [31:0] alu;
        logic [31:0] alu_fp;
        logic [31:0] rdata;
        logic [4:0]  rd;
    } mw_t;

    mw_t exp_q[$];

    always #5 clk = ~clk;

    mem_pipe #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .mem_to_reg_xm(mem_to_reg_xm), .reg_write_xm(reg_write_xm),
        .mem_read_xm(mem_read_xm), .mem_write_xm(mem_write_xm),
        .branch_xm(branch_xm), .fp_operation_xm(fp_operation_xm),
        .alu_out_xm(alu_out_xm), .alu_out_fp_xm(alu_out_fp_xm),
        .rd_addr_xm(rd_addr_xm), .mem_data_xm(mem_data_xm),
        .mem_data_fp_xm(mem_data_fp_xm), .branch_addr_xm(branch_addr_xm),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
        .mem_to_reg_mw(mem_to_reg_mw), .reg_write_mw(reg_write_mw),
        .fp_operation_mw(fp_operation_mw), .alu_out_mw(alu_out_mw),
        .alu_out_fp_mw(alu_out_fp_mw), .mem_rdata_mw(mem_rdata_mw),
        .rd_addr_mw(rd_addr_mw), .mem_err(mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_xm();
        mem_to_reg_xm = 0; reg_write_xm = 0; mem_read_xm = 0; mem_write_xm = 0;
        branch_xm = 0; fp_operation_xm = 0;
        alu_out_xm = '0; alu_out_fp_xm = '0; rd_addr_xm = '0;
        mem_data_xm = '0; mem_data_fp_xm = '0; branch_addr_xm = '0;
    endtask

    task automatic push_mw(input logic mtr, input logic rw, input logic fp, input logic [31:0] alu,
                           input logic [31:0] alu_fp, input logic [31:0] rdata, input logic [4:0] rd);
        mw_t e;
        e.mtr = mtr; e.rw = rw; e.fp = fp; e.alu = alu; e.alu_fp = alu_fp; e.rdata = rdata; e.rd = rd;
        exp_q.push_back(e);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        mw_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mem_to_reg_mw", mem_to_reg_mw, e.mtr);
            chk("reg_write_mw", reg_write_mw, e.rw);
            chk("fp_operation_mw", fp_operation_mw, e.fp);
            chk("alu_out_mw", alu_out_mw, e.alu);
            chk("alu_out_fp_mw", alu_out_fp_mw, e.alu_fp);
            chk("mem_rdata_mw", mem_rdata_mw, e.rdata);
            chk("rd_addr_mw", rd_addr_mw, e.rd);
        end
    endtask

    task automatic chk_comb(input string tag, input logic req, input logic stl, input logic pcs);
        #1;
        chk({tag, ".dmem_req"}, dmem_req, req);
        chk({tag, ".stall"}, stall, stl);
        chk({tag, ".pc_src"}, pc_src, pcs);
    endtask

    initial begin
        rst = 1; dmem_ack = 0; dmem_rdata = '0;
        clear_xm();
        tick(); tick();
        chk("rst.dmem_req", dmem_req, 0);
        chk("rst.stall", stall, 0);
        rst = 0;
        chk("rst.reg_write_mw", reg_write_mw, 0);
        chk("rst.alu_out_mw", alu_out_mw, 0);
        chk("rst.mem_err", mem_err, 0);

        // ALU passthrough
        reg_write_xm = 1; alu_out_xm = 32'h2A; rd_addr_xm = 5;
        chk_comb("alu", 0, 0, 0);
        push_mw(0, 1, 0, 32'h2A, 0, 0, 5);
        tick();

        // Zero-wait lw
        clear_xm();
        mem_read_xm = 1; mem_to_reg_xm = 1; reg_write_xm = 1; alu_out_xm = 32'h100; rd_addr_xm = 3;
        dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
        chk_comb("lw0", 1, 0, 0);
        chk("lw0.dmem_we", dmem_we, 0);
        chk("lw0.dmem_addr", dmem_addr, 32'h100);
        push_mw(1, 1, 0, 32'h100, 0, 32'hDEADBEEF, 3);
        tick();

        // swc1 with three wait cycles
        clear_xm(); dmem_ack = 0; dmem_rdata = 32'h0BAD_0BAD;
        fp_operation_xm = 1; mem_write_xm = 1; alu_out_fp_xm = 32'h200;
        mem_data_fp_xm = 32'h3F80_0000; alu_out_xm = 32'h55; mem_data_xm = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            chk_comb("swc1.wait", 1, 1, 0);
            chk("swc1.dmem_we", dmem_we, 1);
            chk("swc1.dmem_addr", dmem_addr, 32'h200);
            chk("swc1.dmem_wdata", dmem_wdata, 32'h3F80_0000);
            push_mw(0, 0, 0, 32'h100, 0, 32'hDEADBEEF, 3);
            tick();
        end
        dmem_ack = 1;
        chk_comb("swc1.ack", 1, 0, 0);
        push_mw(0, 0, 1, 32'h55, 32'h200, 0, 0);
        tick();
        chk("swc1.mem_err", mem_err, 0);

        // Timeout on lw (TIMEOUT=4)
        clear_xm(); dmem_ack = 0;
        mem_read_xm = 1; mem_to_reg_xm = 1; reg_write_xm = 1; alu_out_xm = 32'h300; rd_addr_xm = 7;
        for (int i = 0; i < 4; i++) begin
            chk_comb("tmo.wait", 1, 1, 0);
            push_mw(0, 0, 0, 32'h55, 32'h200, 0, 0);
            tick();
        end
        chk_comb("tmo.abort", 1, 0, 0);
        push_mw(0, 0, 0, 32'h300, 0, 0, 7);
        tick();
        chk("tmo.mem_err", mem_err, 1);
        clear_xm();
        reg_write_xm = 1; alu_out_xm = 32'h77; rd_addr_xm = 1;
        chk_comb("tmo.idle", 0, 0, 0);
        push_mw(0, 1, 0, 32'h77, 0, 0, 1);
        tick();

        // Reset on the second WAIT cycle
        clear_xm();
        mem_read_xm = 1; mem_to_reg_xm = 1; reg_write_xm = 1; alu_out_xm = 32'h400; rd_addr_xm = 4;
        chk_comb("rstw.idle", 1, 1, 0);
        push_mw(0, 0, 0, 32'h77, 0, 0, 1);
        tick();
        chk_comb("rstw.wait1", 1, 1, 0);
        push_mw(0, 0, 0, 32'h77, 0, 0, 1);
        tick();
        rst = 1;
        chk_comb("rstw.rst", 0, 0, 0);
        push_mw(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("rstw.mem_err", mem_err, 0);
        rst = 0;
        clear_xm(); dmem_ack = 1; dmem_rdata = 32'h1234_5678;
        chk_comb("rstw.stray", 0, 0, 0);
        push_mw(0, 0, 0, 0, 0, 0, 0);
        tick();
        dmem_ack = 0;

        // Misaligned lw, then a branch
        mem_read_xm = 1; mem_to_reg_xm = 1; reg_write_xm = 1; alu_out_xm = 32'h102; rd_addr_xm = 9;
        chk_comb("mis", 0, 0, 0);
        push_mw(0, 0, 0, 32'h102, 0, 0, 9);
        tick();
        chk("mis.mem_err", mem_err, 1);
        clear_xm();
        branch_xm = 1; branch_addr_xm = 32'h40;
        chk_comb("br", 0, 0, 1);
        chk("br.branch_target", branch_target, 32'h40);
        push_mw(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("br.mem_err_sticky", mem_err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
